// File: rtl/midi_rt_pkg.sv
// MIDI real-time status bytes and transport state encoding shared by the
// clock tracker and its handshake front end.
package midi_rt_pkg;

    localparam logic [7:0] RT_CLOCK = 8'hF8;
    localparam logic [7:0] RT_START = 8'hFA;
    localparam logic [7:0] RT_CONT  = 8'hFB;
    localparam logic [7:0] RT_STOP  = 8'hFC;
    localparam logic [7:0] RT_SENSE = 8'hFE;
    localparam logic [7:0] RT_RESET = 8'hFF;

    typedef enum logic [1:0] {
        STOPPED = 2'd0,
        ARMED   = 2'd1,
        RUNNING = 2'd2
    } xport_state_t;

endpackage

// File: rtl/midi_clock_tracker_if.sv
// Four-phase req/ack link carrying one real-time status byte per handshake
// from the CLOCK_25-domain UART shim (master) to the tracker (slave).
interface midi_clock_tracker_if;

    logic       rt_req;
    logic [7:0] rt_dat;
    logic       rt_ack;

    modport master (output rt_req, output rt_dat, input rt_ack);
    modport slave  (input rt_req, input rt_dat, output rt_ack);

endinterface

// File: rtl/rt_req_sync.sv
// Brings the asynchronous rt_req into sysclk: two-flop synchronizer for the
// acknowledge, plus a third flop so each handshake yields one event strobe.
module rt_req_sync (
    input  logic sysclk,
    input  logic reset1,
    input  logic req_async,
    output logic rt_ack,
    output logic evt
);

    logic s1_q, s1_d;
    logic s2_q, s2_d;
    logic s3_q, s3_d;

    // NOTE: pure next-value logic with no conditional paths, so nothing can
    // be left unassigned and no latch can be inferred.
    always_comb begin
        s1_d = req_async;
        s2_d = s1_q;
        s3_d = s2_q;
    end

    // NOTE: state updates use <= so every flop samples pre-edge values and the
    // shift chain cannot collapse into a single stage.
    always_ff @(posedge sysclk or negedge reset1) begin
        if (!reset1) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
            s3_q <= 1'b0;
        end else begin
            s1_q <= s1_d;
            s2_q <= s2_d;
            s3_q <= s3_d;
        end
    end

    // Async reset clears s2 at once, so the shim sees ack drop as an abort.
    assign rt_ack = s2_q;
    assign evt    = s2_q & ~s3_q;

endmodule

// File: rtl/midi_clock_tracker.sv
// Tracks MIDI transport (start/continue/stop/clock/reset) in the slow sysclk
// domain: transport state, beat pulse, tick position and quarter-note period.
module midi_clock_tracker
    import midi_rt_pkg::*;
#(
    parameter int unsigned PPQN    = 24,
    parameter int unsigned CNT_W   = 16,
    parameter int unsigned TIMEOUT = 4096,
    parameter int unsigned TICK_W  = 5
) (
    input  logic                  sysclk,
    input  logic                  reset1,
    midi_clock_tracker_if.slave   rt,
    output logic                  running,
    output logic                  beat,
    output logic [TICK_W-1:0]     tick_pos,
    output logic [CNT_W-1:0]      period,
    output logic                  period_valid,
    output logic                  clk_lost
);

    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(PPQN - 1);
    localparam logic [CNT_W-1:0]  IVL_LIMIT = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};

    logic evt;

    rt_req_sync u_sync (
        .sysclk    (sysclk),
        .reset1    (reset1),
        .req_async (rt.rt_req),
        .rt_ack    (rt.rt_ack),
        .evt       (evt)
    );

    // rt_dat is held stable by the shim while rt_req is high, so it is safe
    // to use directly on the event cycle.
    logic ev_clock, ev_start, ev_cont, ev_stop, ev_reset;

    always_comb begin
        ev_clock = evt && (rt.rt_dat == RT_CLOCK);
        ev_start = evt && (rt.rt_dat == RT_START);
        ev_cont  = evt && (rt.rt_dat == RT_CONT);
        ev_stop  = evt && (rt.rt_dat == RT_STOP);
        ev_reset = evt && (rt.rt_dat == RT_RESET);
    end

    xport_state_t state_q, state_d;

    logic              running_q, running_d;
    logic              beat_q, beat_d;
    logic [TICK_W-1:0] tick_q, tick_d;
    logic [TICK_W-1:0] tick_inc;

    logic [CNT_W-1:0]  interval_q, interval_d;
    logic [CNT_W-1:0]  acc_q, acc_d;
    logic [TICK_W-1:0] acc_cnt_q, acc_cnt_d;
    logic [CNT_W-1:0]  period_q, period_d;
    logic              period_valid_q, period_valid_d;
    logic              clk_lost_q, clk_lost_d;

    logic [CNT_W:0]    acc_sum_w;
    logic [CNT_W-1:0]  acc_sum;

    always_ff @(posedge sysclk or negedge reset1) begin
        if (!reset1) state_q <= STOPPED;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (ev_reset) begin
            state_d = STOPPED;
        end else begin
            case (state_q)
                STOPPED: if (ev_start || ev_cont) state_d = ARMED;
                ARMED: begin
                    if (ev_clock)     state_d = RUNNING;
                    else if (ev_stop) state_d = STOPPED;
                end
                RUNNING: begin
                    if (ev_stop)       state_d = STOPPED;
                    else if (ev_start) state_d = ARMED;
                end
                default: state_d = STOPPED;
            endcase
        end
    end

    always_comb begin
        tick_inc  = (tick_q == TICK_LAST) ? '0 : tick_q + TICK_W'(1);
        tick_d    = tick_q;
        beat_d    = 1'b0;
        running_d = (state_d == RUNNING);
        if (ev_reset) begin
            tick_d = '0;
        end else begin
            case (state_q)
                STOPPED: if (ev_start) tick_d = '0;
                ARMED: begin
                    // A fresh start holds position 0 for the first clock;
                    // a continue resumes advancing from where it stopped.
                    if (ev_clock) begin
                        if (tick_q == '0) begin
                            beat_d = 1'b1;
                        end else begin
                            tick_d = tick_inc;
                            beat_d = (tick_inc == '0);
                        end
                    end else if (ev_start) begin
                        tick_d = '0;
                    end
                end
                RUNNING: begin
                    if (ev_clock) begin
                        tick_d = tick_inc;
                        beat_d = (tick_inc == '0);
                    end else if (ev_start) begin
                        tick_d = '0;
                    end
                end
                default: tick_d = tick_q;
            endcase
        end
    end

    // Once acc hits all-ones every later add saturates too, so saturation
    // persists until the window is closed or discarded.
    always_comb begin
        acc_sum_w = {1'b0, acc_q} + {1'b0, interval_q} + (CNT_W + 1)'(1);
        acc_sum   = acc_sum_w[CNT_W] ? CNT_MAX : acc_sum_w[CNT_W-1:0];
    end

    always_comb begin
        interval_d     = (interval_q == CNT_MAX) ? interval_q : interval_q + CNT_W'(1);
        acc_d          = acc_q;
        acc_cnt_d      = acc_cnt_q;
        period_d       = period_q;
        period_valid_d = period_valid_q;
        clk_lost_d     = clk_lost_q;

        if (ev_clock) begin
            interval_d = '0;
            clk_lost_d = 1'b0;
            // The first clock after a loss only re-establishes the interval.
            if (!clk_lost_q) begin
                if (acc_cnt_q == TICK_LAST) begin
                    period_d       = acc_sum;
                    period_valid_d = 1'b1;
                    acc_d          = '0;
                    acc_cnt_d      = '0;
                end else begin
                    acc_d     = acc_sum;
                    acc_cnt_d = acc_cnt_q + TICK_W'(1);
                end
            end
        end else if (interval_q == IVL_LIMIT) begin
            clk_lost_d     = 1'b1;
            period_valid_d = 1'b0;
            acc_d          = '0;
            acc_cnt_d      = '0;
        end

        if (ev_reset) begin
            period_d       = '0;
            period_valid_d = 1'b0;
            acc_d          = '0;
            acc_cnt_d      = '0;
        end
    end

    always_ff @(posedge sysclk or negedge reset1) begin
        if (!reset1) begin
            running_q      <= 1'b0;
            beat_q         <= 1'b0;
            tick_q         <= '0;
            interval_q     <= '0;
            acc_q          <= '0;
            acc_cnt_q      <= '0;
            period_q       <= '0;
            period_valid_q <= 1'b0;
            clk_lost_q     <= 1'b1;
        end else begin
            running_q      <= running_d;
            beat_q         <= beat_d;
            tick_q         <= tick_d;
            interval_q     <= interval_d;
            acc_q          <= acc_d;
            acc_cnt_q      <= acc_cnt_d;
            period_q       <= period_d;
            period_valid_q <= period_valid_d;
            clk_lost_q     <= clk_lost_d;
        end
    end

    assign running      = running_q;
    assign beat         = beat_q;
    assign tick_pos     = tick_q;
    assign period       = period_q;
    assign period_valid = period_valid_q;
    assign clk_lost     = clk_lost_q;

endmodule

// File: tb/tb_midi_clock_tracker.sv
// Directed bench for midi_clock_tracker: transport, beat, tempo period,
// clock-loss timeout, system reset and handshake behaviour.
module tb_midi_clock_tracker;

    logic        sysclk = 1'b0;
    logic        reset1 = 1'b0;
    logic        rt_req = 1'b0;
    logic [7:0]  rt_dat = 8'h00;
    logic        running, beat, period_valid, clk_lost;
    logic [4:0]  tick_pos;
    logic [15:0] period;
    logic        rt_ack;

    int checks = 0;
    int errors = 0;

    midi_clock_tracker_if rt_if ();
    assign rt_if.rt_req = rt_req;
    assign rt_if.rt_dat = rt_dat;
    assign rt_ack       = rt_if.rt_ack;

    midi_clock_tracker dut (
        .sysclk       (sysclk),
        .reset1       (reset1),
        .rt           (rt_if),
        .running      (running),
        .beat         (beat),
        .tick_pos     (tick_pos),
        .period       (period),
        .period_valid (period_valid),
        .clk_lost     (clk_lost)
    );

    always #5 sysclk = ~sysclk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d expected=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge sysclk);
        #1;
    endtask

    // Returns 1 time unit after the edge on which the byte takes effect.
    task automatic send(input logic [7:0] b);
        int n;
        @(negedge sysclk);
        rt_dat = b;
        rt_req = 1'b1;
        n = 0;
        do begin
            @(negedge sysclk);
            n++;
        end while (!rt_ack && n < 8);
        check("ack_latency", n, 2);
        rt_req = 1'b0;
        @(posedge sysclk);
        #1;
    endtask

    initial begin
        int pad;
        int n;

        #23 reset1 = 1'b1;

        // Idle after reset.
        idle(5000);
        check("idle_clk_lost", clk_lost, 1);
        check("idle_valid", period_valid, 0);
        check("idle_running", running, 0);
        check("idle_beat", beat, 0);
        check("idle_tick", tick_pos, 0);
        check("idle_period", period, 0);
        check("idle_ack", rt_ack, 0);

        // Start, then 48 clocks at 500-cycle spacing.
        idle(497);
        send(8'hFA);
        check("start_running", running, 0);
        pad = 497;
        for (int i = 1; i <= 48; i++) begin
            idle(pad);
            pad = 497;
            send(8'hF8);
            check($sformatf("beat_f8_%0d", i), beat, (i == 1 || i == 25) ? 1 : 0);
            check($sformatf("run_f8_%0d", i), running, 1);
            if (i == 1) begin
                check("tick_f8_1", tick_pos, 0);
                check("clk_lost_f8_1", clk_lost, 0);
                idle(1);
                check("beat_one_cycle", beat, 0);
                pad = 496;
            end
            if (i == 24) begin
                check("tick_f8_24", tick_pos, 23);
                check("valid_f8_24", period_valid, 0);
            end
            if (i == 25) begin
                check("period_f8_25", period, 12000);
                check("valid_f8_25", period_valid, 1);
                check("tick_f8_25", tick_pos, 0);
            end
        end
        check("tick_f8_48", tick_pos, 23);

        // Advance to tick 10, stop, clock while stopped, continue.
        for (int i = 49; i <= 59; i++) begin
            idle(497);
            send(8'hF8);
            if (i == 49) begin
                check("beat_f8_49", beat, 1);
                check("period_f8_49", period, 12000);
            end
        end
        check("tick_before_stop", tick_pos, 10);
        idle(497);
        send(8'hFC);
        check("stop_running", running, 0);
        check("stop_tick", tick_pos, 10);
        for (int i = 0; i < 5; i++) begin
            idle(497);
            send(8'hF8);
            check("stopped_tick", tick_pos, 10);
            check("stopped_running", running, 0);
            check("stopped_beat", beat, 0);
        end
        idle(497);
        send(8'hFB);
        check("cont_running", running, 0);
        check("cont_tick", tick_pos, 10);
        idle(497);
        send(8'hF8);
        check("cont_f8_running", running, 1);
        check("cont_f8_tick", tick_pos, 11);
        check("cont_f8_beat", beat, 0);

        // Clock gap: loss exactly 4096 cycles after the last clock.
        for (int i = 0; i < 3; i++) begin
            idle(497);
            send(8'hF8);
        end
        check("pre_gap_valid", period_valid, 1);
        idle(4095);
        check("gap_4095_lost", clk_lost, 0);
        check("gap_4095_valid", period_valid, 1);
        idle(1);
        check("gap_4096_lost", clk_lost, 1);
        check("gap_4096_valid", period_valid, 0);
        check("gap_running", running, 1);
        idle(904);
        send(8'hF8);
        check("resume_lost", clk_lost, 0);
        check("resume_valid", period_valid, 0);
        for (int k = 1; k <= 24; k++) begin
            idle(497);
            send(8'hF8);
            if (k == 23) check("resume_valid_24", period_valid, 0);
            if (k == 24) begin
                check("resume_valid_25", period_valid, 1);
                check("resume_period_25", period, 12000);
            end
        end

        // System reset while running with a valid period.
        idle(497);
        send(8'hFF);
        check("ff_running", running, 0);
        check("ff_tick", tick_pos, 0);
        check("ff_period", period, 0);
        check("ff_valid", period_valid, 0);

        // Handshake: long request yields one tick; ack follows req by 2 edges.
        idle(10);
        send(8'hFA);
        idle(497);
        send(8'hF8);
        check("hs_start_running", running, 1);
        check("hs_start_beat", beat, 1);
        check("hs_start_tick", tick_pos, 0);
        idle(10);
        @(negedge sysclk);
        rt_dat = 8'hF8;
        rt_req = 1'b1;
        @(posedge sysclk); #1;
        check("ack_edge1", rt_ack, 0);
        @(posedge sysclk); #1;
        check("ack_edge2", rt_ack, 1);
        check("hs_tick_pending", tick_pos, 0);
        @(posedge sysclk); #1;
        check("hs_tick_edge3", tick_pos, 1);
        idle(47);
        check("hs_tick_held", tick_pos, 1);
        check("hs_ack_held", rt_ack, 1);
        rt_req = 1'b0;
        n = 0;
        while (rt_ack && n < 8) begin
            @(posedge sysclk); #1;
            n++;
        end
        check("ack_drop", rt_ack, 0);
        idle(5);
        send(8'hFE);
        check("fe_tick", tick_pos, 1);
        check("fe_running", running, 1);
        check("fe_beat", beat, 0);
        idle(5);
        send(8'h3C);
        check("data_byte_tick", tick_pos, 1);
        check("data_byte_running", running, 1);

        // Reset in the middle of a handshake drops ack immediately.
        idle(5);
        @(negedge sysclk);
        rt_dat = 8'hF8;
        rt_req = 1'b1;
        @(posedge sysclk);
        @(posedge sysclk); #1;
        check("mid_hs_ack", rt_ack, 1);
        reset1 = 1'b0;
        #1;
        check("rst_ack", rt_ack, 0);
        check("rst_running", running, 0);
        check("rst_tick", tick_pos, 0);
        check("rst_clk_lost", clk_lost, 1);
        rt_req = 1'b0;
        idle(3);
        reset1 = 1'b1;
        idle(3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
